// File: rtl/cpu_pkg.sv
// Shared core definitions: read-return owner encoding for the memory arbiter
// and the MMIO addresses used by the upstream address decoder.
package cpu_pkg;

  // Which port the word on ram_rdata belongs to in the current cycle.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_INST = 2'd1,
    OWN_DATA = 2'd2
  } owner_e;

  // MMIO map, decoded before the arbiter; d_req never carries these.
  localparam logic [31:0] SEG_ADDR  = 32'h0000_0000;
  localparam logic [31:0] UART_ADDR = 32'h0000_0004;

endpackage

// File: rtl/mem_arbiter_starve_counter.sv
// Saturating counter of consecutive data grants taken while a fetch waits.
// clr has priority over inc; at_max tells the arbiter to force a fetch grant.
module starve_counter #(
  parameter int unsigned MAX = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  output logic at_max
);

  localparam int unsigned CW = (MAX < 1) ? 1 : $clog2(MAX + 1);

  logic [CW-1:0] cnt;

  assign at_max = (cnt == CW'(MAX));

  // Count data grants taken over a waiting fetch; hold once saturated.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !at_max) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port synchronous RAM (1-cycle read latency) between the
// instruction-fetch port and the data load/store port. Data has priority; a
// starvation counter forces a fetch grant after STARVE_MAX data grants taken
// while a fetch was waiting.
//
// Handshake (both ports): the requester raises X_req with stable address
// (and d_we/d_wdata) and holds it until X_gnt; a transfer occurs in every
// cycle where X_req & X_gnt. Dropping X_req before the grant is allowed and
// has no effect. A granted read returns with X_rvalid exactly one cycle
// later, with X_rdata valid in that same cycle; stores never return.
module mem_arbiter
  import cpu_pkg::*;
#(
  parameter int unsigned AW         = 15,
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned DW         = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  // Instruction fetch port
  input  logic          i_req,
  input  logic [31:0]   i_addr,
  output logic          i_gnt,
  output logic          i_rvalid,
  output logic [DW-1:0] i_rdata,
  // Data load/store port
  input  logic          d_req,
  input  logic          d_we,
  input  logic [31:0]   d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  // Single-port RAM
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata
);

  logic          force_i;
  logic          at_max;
  owner_e        owner_q;
  owner_e        owner_d;
  logic [DW-1:0] i_rdata_q;
  logic [DW-1:0] d_rdata_q;

  // Byte-lane and high address bits are intentionally ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_addr[31:AW+2], i_addr[1:0],
                              d_addr[31:AW+2], d_addr[1:0]};

  // ---------------------------------------------------------------------
  // Grant: data first unless the fetch has waited STARVE_MAX data grants.
  // Both grants are held low while reset is asserted.
  // ---------------------------------------------------------------------
  assign force_i = i_req & at_max;
  assign d_gnt   = rst_n & d_req & ~force_i;
  assign i_gnt   = rst_n & i_req & ~d_gnt;

  starve_counter #(
    .MAX (STARVE_MAX)
  ) u_starve (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc    (d_gnt & i_req),
    .clr    (i_gnt | ~i_req),
    .at_max (at_max)
  );

  // ---------------------------------------------------------------------
  // RAM drive: the granted port's word address; fetch address when idle.
  // ---------------------------------------------------------------------
  assign ram_addr  = d_gnt ? d_addr[AW+1:2] : i_addr[AW+1:2];
  assign ram_we    = d_gnt & d_we;
  assign ram_wdata = d_wdata;

  // Next read owner: whoever issued a read this cycle; stores leave NONE.
  always_comb begin
    owner_d = OWN_NONE;
    if (i_gnt) begin
      owner_d = OWN_INST;
    end else if (d_gnt && !d_we) begin
      owner_d = OWN_DATA;
    end
  end

  // Owner register: marks the cycle in which ram_rdata belongs to a port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q <= OWN_NONE;
    end else begin
      owner_q <= owner_d;
    end
  end

  // ---------------------------------------------------------------------
  // Return path: rvalid is a decode of the owner register. rdata shows the
  // RAM word during the return cycle and the held copy afterwards, so the
  // word and its rvalid line up one cycle after the grant.
  // ---------------------------------------------------------------------
  assign i_rvalid = (owner_q == OWN_INST);
  assign d_rvalid = (owner_q == OWN_DATA);

  assign i_rdata = i_rvalid ? ram_rdata : i_rdata_q;
  assign d_rdata = d_rvalid ? ram_rdata : d_rdata_q;

  // Hold the last returned word of each port; the other port is untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      if (i_rvalid) begin
        i_rdata_q <= ram_rdata;
      end
      if (d_rvalid) begin
        d_rdata_q <= ram_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a 1-cycle-latency single-port RAM model.
module tb_mem_arbiter;

  localparam int AW         = 15;
  localparam int DW         = 32;
  localparam int STARVE_MAX = 4;

  logic          clk;
  logic          rst_n;
  logic          i_req;
  logic [31:0]   i_addr;
  logic          i_gnt;
  logic          i_rvalid;
  logic [DW-1:0] i_rdata;
  logic          d_req;
  logic          d_we;
  logic [31:0]   d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_gnt;
  logic          d_rvalid;
  logic [DW-1:0] d_rdata;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;

  // RAM preload path (only used during reset)
  logic          pl_we;
  logic [AW-1:0] pl_addr;
  logic [DW-1:0] pl_data;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  logic [DW-1:0] exp_q[$];
  int n_cmp;
  int n_err;

  mem_arbiter #(
    .AW         (AW),
    .STARVE_MAX (STARVE_MAX),
    .DW         (DW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .i_gnt     (i_gnt),
    .i_rvalid  (i_rvalid),
    .i_rdata   (i_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_gnt     (d_gnt),
    .d_rvalid  (d_rvalid),
    .d_rdata   (d_rdata),
    .ram_addr  (ram_addr),
    .ram_we    (ram_we),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- RAM model ----------------
  always @(posedge clk) begin
    if (pl_we) begin
      mem[pl_addr] <= pl_data;
    end else if (ram_we) begin
      mem[ram_addr] <= ram_wdata;
    end
    ram_rdata <= mem[ram_addr];
  end

  // ---------------- checker ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] v);
    pl_we   = 1'b1;
    pl_addr = a;
    pl_data = v;
    @(posedge clk);
    #1;
    pl_we   = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  logic [9:0]    pattern;
  logic          exp_d_bit;
  logic          exp_i_bit;
  logic [DW-1:0] hold_i;
  logic [DW-1:0] hold_d;
  logic [DW-1:0] exp_w;

  initial begin
    n_cmp   = 0;
    n_err   = 0;
    rst_n   = 1'b0;
    i_req   = 1'b1;
    d_req   = 1'b1;
    d_we    = 1'b0;
    i_addr  = 32'h0;
    d_addr  = 32'h0;
    d_wdata = '0;
    pl_we   = 1'b0;
    pl_addr = '0;
    pl_data = '0;

    // Preload while held in reset with both requests asserted.
    preload(15'h00, 32'hA0A0_0000);
    preload(15'h01, 32'hA1A1_0001);
    preload(15'h10, 32'hDEAD_BEEF);
    preload(15'h40, 32'hD0D0_0100);
    preload(15'h41, 32'hD1D1_0104);

    // ---- reset with requests asserted ----
    #1;
    chk("rst_i_gnt", i_gnt, 0);
    chk("rst_d_gnt", d_gnt, 0);
    chk("rst_i_rvalid", i_rvalid, 0);
    chk("rst_d_rvalid", d_rvalid, 0);
    chk("rst_i_rdata", i_rdata, 0);
    chk("rst_d_rdata", d_rdata, 0);
    rst_n = 1'b1;
    #1;
    chk("rel_d_gnt", d_gnt, 1);
    chk("rel_i_gnt", i_gnt, 0);
    step();
    chk("rel_d_rvalid", d_rvalid, 1);
    chk("rel_d_rdata", d_rdata, 32'hA0A0_0000);
    chk("rel_i_rvalid", i_rvalid, 0);
    i_req = 1'b0;
    d_req = 1'b0;
    step();
    chk("idle_d_rvalid", d_rvalid, 0);
    chk("idle_d_hold", d_rdata, 32'hA0A0_0000);

    // ---- fetch only ----
    i_req  = 1'b1;
    i_addr = 32'h40;
    #1;
    chk("f_i_gnt", i_gnt, 1);
    chk("f_d_gnt", d_gnt, 0);
    chk("f_ram_addr", 32'(ram_addr), 32'h10);
    chk("f_ram_we", ram_we, 0);
    step();
    i_req = 1'b0;
    #1;
    chk("f_i_rvalid", i_rvalid, 1);
    chk("f_i_rdata", i_rdata, 32'hDEAD_BEEF);
    chk("f_d_rvalid", d_rvalid, 0);
    step();
    chk("f_i_rvalid_off", i_rvalid, 0);
    chk("f_i_hold", i_rdata, 32'hDEAD_BEEF);

    // ---- store then load, same address ----
    d_req   = 1'b1;
    d_we    = 1'b1;
    d_addr  = 32'h80;
    d_wdata = 32'h1234_5678;
    #1;
    chk("st_d_gnt", d_gnt, 1);
    chk("st_ram_we", ram_we, 1);
    chk("st_ram_addr", 32'(ram_addr), 32'h20);
    chk("st_ram_wdata", ram_wdata, 32'h1234_5678);
    step();
    chk("st_d_rvalid", d_rvalid, 0);
    d_we = 1'b0;
    #1;
    chk("ld_ram_we", ram_we, 0);
    chk("ld_d_gnt", d_gnt, 1);
    step();
    d_req = 1'b0;
    chk("ld_d_rvalid", d_rvalid, 1);
    chk("ld_d_rdata", d_rdata, 32'h1234_5678);
    step();

    // ---- contention / starvation: D D D D I D D D D I ----
    pattern = 10'b11110_11110;
    i_req   = 1'b1;
    d_req   = 1'b1;
    d_we    = 1'b0;
    i_addr  = 32'h0;
    d_addr  = 32'h100;
    for (int k = 0; k < 10; k++) begin
      exp_d_bit = pattern[9-k];
      exp_i_bit = !exp_d_bit;
      #1;
      chk($sformatf("cont%0d_d_gnt", k), d_gnt, exp_d_bit);
      chk($sformatf("cont%0d_i_gnt", k), i_gnt, exp_i_bit);
      chk($sformatf("cont%0d_both", k), i_gnt & d_gnt, 0);
      step();
    end
    i_req = 1'b0;
    d_req = 1'b0;
    step();

    // ---- pipelined interleave: fetch 0x0/0x4 with loads 0x100/0x104 ----
    // Last returns above: fetch of 0x0 (k=9) and load of 0x100 (k=8).
    hold_i = 32'hA0A0_0000;
    hold_d = 32'hD0D0_0100;
    for (int k = 0; k < 8; k++) begin
      if (k % 2 == 0) begin
        i_req  = 1'b1;
        d_req  = 1'b0;
        i_addr = ((k / 2) % 2 == 1) ? 32'h4 : 32'h0;
        exp_q.push_back(((k / 2) % 2 == 1) ? 32'hA1A1_0001 : 32'hA0A0_0000);
        #1;
        chk($sformatf("il%0d_i_gnt", k), i_gnt, 1);
      end else begin
        d_req  = 1'b1;
        i_req  = 1'b0;
        d_addr = ((k / 2) % 2 == 1) ? 32'h104 : 32'h100;
        exp_q.push_back(((k / 2) % 2 == 1) ? 32'hD1D1_0104 : 32'hD0D0_0100);
        #1;
        chk($sformatf("il%0d_d_gnt", k), d_gnt, 1);
      end
      step();
      exp_w = exp_q.pop_front();
      if (k % 2 == 0) begin
        chk($sformatf("il%0d_i_rvalid", k), i_rvalid, 1);
        chk($sformatf("il%0d_i_rdata", k), i_rdata, exp_w);
        chk($sformatf("il%0d_d_rvalid", k), d_rvalid, 0);
        chk($sformatf("il%0d_d_hold", k), d_rdata, hold_d);
        hold_i = exp_w;
      end else begin
        chk($sformatf("il%0d_d_rvalid", k), d_rvalid, 1);
        chk($sformatf("il%0d_d_rdata", k), d_rdata, exp_w);
        chk($sformatf("il%0d_i_rvalid", k), i_rvalid, 0);
        chk($sformatf("il%0d_i_hold", k), i_rdata, hold_i);
        hold_d = exp_w;
      end
    end
    i_req = 1'b0;
    d_req = 1'b0;
    step();

    // ---- reset in the return cycle of a load ----
    d_req  = 1'b1;
    d_we   = 1'b0;
    d_addr = 32'h100;
    #1;
    chk("mr_d_gnt", d_gnt, 1);
    step();
    d_req = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mr_d_rvalid", d_rvalid, 0);
    chk("mr_d_rdata", d_rdata, 0);
    chk("mr_i_rdata", i_rdata, 0);
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("mr_post%0d_d_rvalid", k), d_rvalid, 0);
      chk($sformatf("mr_post%0d_i_rvalid", k), i_rvalid, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
